// File: rtl/mem32_bridge.sv
// mem32_bridge: 32-bit request/response bridge onto a 16-bit banked memory port.
// Ports: clk, rst_n (async, active low); req_valid/req_ready/req_we/req_addr/
//   req_wdata/req_be request side; rsp_valid/rsp_rdata/rsp_err response pulse;
//   mem_ai/mem_vi/mem_we/mem_bmsk out and mem_vo in (read data one cycle after
//   the address). Optional MEM32_HALF_EN adds req_half for 16-bit accesses.
module mem32_bridge #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_be,
`ifdef MEM32_HALF_EN
  input  logic          req_half,
`endif
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_ai,
  output logic [15:0]   mem_vi,
  output logic          mem_we,
  output logic [3:0]    mem_bmsk,
  input  logic [15:0]   mem_vo
);

  typedef enum logic [1:0] {IDLE, LO, HI, RD} state_e;

  state_e        state_q, state_d;
  logic          rdy_q;
  logic          we_q, we_d;
  logic          half_q, half_d;
  logic [15:0]   whi_q, whi_d;
  logic [1:0]    bhi_q, bhi_d;
  logic [15:0]   lo_q, lo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] mem_ai_q, mem_ai_d;
  logic [15:0]   mem_vi_q, mem_vi_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_bmsk_q, mem_bmsk_d;

  logic          half_in;
  logic          acc;
  logic          misal;
  logic [AW-1:0] lo_addr;

`ifdef MEM32_HALF_EN
  assign half_in = req_half;
`else
  assign half_in = 1'b0;
`endif

  // rdy_q holds ready low until the first edge after reset release
  assign req_ready = rdy_q && (state_q == IDLE);
  assign acc       = req_valid && req_ready;
  assign misal     = half_in ? req_addr[0] : (req_addr[1:0] != 2'b00);
  assign lo_addr   = half_in ? {req_addr[AW-1:1], 1'b0}
                             : {req_addr[AW-1:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    half_d      = half_q;
    whi_d       = whi_q;
    bhi_d       = bhi_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_ai_d    = mem_ai_q;
    mem_vi_d    = mem_vi_q;
    mem_we_d    = 1'b0;
    mem_bmsk_d  = mem_bmsk_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (misal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d    = LO;
            we_d       = req_we;
            half_d     = half_in;
            whi_d      = req_wdata[31:16];
            bhi_d      = req_be[3:2];
            mem_ai_d   = lo_addr;
            mem_vi_d   = req_wdata[15:0];
            mem_bmsk_d = {req_be[1], req_be[1],
                          req_be[0], req_be[0]};
            mem_we_d   = req_we && (req_be[1:0] != 2'b00);
          end
        end
      end
      LO: begin
        if (half_q) begin
          if (we_q) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d    = HI;
          // LO address is word aligned, so HI is the same word +2
          mem_ai_d   = {mem_ai_q[AW-1:2], 2'b10};
          mem_vi_d   = whi_q;
          mem_bmsk_d = {bhi_q[1], bhi_q[1], bhi_q[0], bhi_q[0]};
          mem_we_d   = we_q && (bhi_q != 2'b00);
        end
      end
      HI: begin
        if (we_q) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          // mem_vo now carries the LO halfword
          lo_d    = mem_vo;
          state_d = RD;
        end
      end
      RD: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = half_q ? {16'h0, mem_vo} : {mem_vo, lo_q};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      we_q        <= 1'b0;
      half_q      <= 1'b0;
      whi_q       <= 16'h0;
      bhi_q       <= 2'b00;
      lo_q        <= 16'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_ai_q    <= '0;
      mem_vi_q    <= 16'h0;
      mem_we_q    <= 1'b0;
      mem_bmsk_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      we_q        <= we_d;
      half_q      <= half_d;
      whi_q       <= whi_d;
      bhi_q       <= bhi_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_ai_q    <= mem_ai_d;
      mem_vi_q    <= mem_vi_d;
      mem_we_q    <= mem_we_d;
      mem_bmsk_q  <= mem_bmsk_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_ai    = mem_ai_q;
  assign mem_vi    = mem_vi_q;
  assign mem_we    = mem_we_q;
  assign mem_bmsk  = mem_bmsk_q;

endmodule

// File: tb/tb_mem32_bridge.sv
// tb_mem32_bridge: directed vector bench for mem32_bridge with a
// 64K x 16 nibble-masked synchronous memory model.
module tb_mem32_bridge;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [16:0] mem_ai;
  logic [15:0] mem_vi;
  logic        mem_we;
  logic [3:0]  mem_bmsk;
  logic [15:0] mem_vo;

  mem32_bridge #(.AW(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_ai    (mem_ai),
    .mem_vi    (mem_vi),
    .mem_we    (mem_we),
    .mem_bmsk  (mem_bmsk),
    .mem_vo    (mem_vo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem_vo = 16'h0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int n = 0; n < 4; n++)
        if (mem_bmsk[n]) mem[mem_ai[16:1]][4*n +: 4] <= mem_vi[4*n +: 4];
    end
    mem_vo <= mem[mem_ai[16:1]];
  end

  typedef struct packed {
    logic [16:0] a;
    logic [15:0] v;
    logic [3:0]  m;
  } wr_t;

  wr_t wlog[$];
  bit  log_en;
  bit  wrap_en;
  int  aiz_cnt;
  bit  rv_en;
  int  rv_cnt;

  always @(negedge clk) begin
    if (log_en && mem_we) wlog.push_back('{a: mem_ai, v: mem_vi, m: mem_bmsk});
    if (wrap_en && mem_ai == 17'h0) aiz_cnt++;
    if (rv_en && rsp_valid) rv_cnt++;
  end

  int ncmp;
  int nbad;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          we;
    logic [16:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          lat;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          nwe;
    logic [16:0] a0;
    logic [15:0] v0;
    logic [3:0]  m0;
    logic [16:0] a1;
    logic [15:0] v1;
    logic [3:0]  m1;
    logic [16:0] ai_end;
  } vec_t;

  task automatic run_req(input vec_t v, input string nm);
    int w;
    int lat;
    wlog.delete();
    log_en = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wd;
    req_be    = v.be;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      lat = c;
      if (rsp_valid) break;
    end
    chk({nm, " latency"}, lat, v.lat);
    chk({nm, " err"}, {31'h0, rsp_err}, {31'h0, v.err});
    if (v.chk_rd) chk({nm, " rdata"}, rsp_rdata, v.rd);
    chk({nm, " ai_end"}, {15'h0, mem_ai}, {15'h0, v.ai_end});
    chk({nm, " nwe"}, wlog.size(), v.nwe);
    if (v.nwe > 0 && wlog.size() == v.nwe) begin
      chk({nm, " ai0"}, {15'h0, wlog[0].a}, {15'h0, v.a0});
      chk({nm, " vi0"}, {16'h0, wlog[0].v}, {16'h0, v.v0});
      chk({nm, " bm0"}, {28'h0, wlog[0].m}, {28'h0, v.m0});
      chk({nm, " ai1"}, {15'h0, wlog[v.nwe-1].a}, {15'h0, v.a1});
      chk({nm, " vi1"}, {16'h0, wlog[v.nwe-1].v}, {16'h0, v.v1});
      chk({nm, " bm1"}, {28'h0, wlog[v.nwe-1].m}, {28'h0, v.m1});
    end
    log_en = 1'b0;
  endtask

  vec_t vt[12];
  vec_t vr;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    ncmp = 0; nbad = 0;
    log_en = 0; wrap_en = 0; aiz_cnt = 0; rv_en = 0; rv_cnt = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;

    vt[0]  = '{1, 17'h00100, 32'h12345678, 4'hF, 3, 0, 0, 32'h0, 2,
               17'h00100, 16'h5678, 4'hF, 17'h00102, 16'h1234, 4'hF, 17'h00102};
    vt[1]  = '{0, 17'h00100, 32'h0, 4'hF, 4, 0, 1, 32'h12345678, 0,
               17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h00102};
    vt[2]  = '{1, 17'h00100, 32'hAABBCCDD, 4'h4, 3, 0, 0, 32'h0, 1,
               17'h00102, 16'hAABB, 4'h3, 17'h00102, 16'hAABB, 4'h3, 17'h00102};
    vt[3]  = '{0, 17'h00100, 32'h0, 4'hF, 4, 0, 1, 32'h12BB5678, 0,
               17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h00102};
    vt[4]  = '{0, 17'h00102, 32'h0, 4'hF, 1, 1, 1, 32'h0, 0,
               17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h00102};
    vt[5]  = '{1, 17'h00200, 32'hDEADBEEF, 4'h0, 3, 0, 0, 32'h0, 0,
               17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h00202};
    vt[6]  = '{0, 17'h00200, 32'h0, 4'hF, 4, 0, 1, 32'h00000000, 0,
               17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h00202};
    vt[7]  = '{1, 17'h00204, 32'hCAFEF00D, 4'h3, 3, 0, 0, 32'h0, 1,
               17'h00204, 16'hF00D, 4'hF, 17'h00204, 16'hF00D, 4'hF, 17'h00206};
    vt[8]  = '{0, 17'h00204, 32'h0, 4'hF, 4, 0, 1, 32'h0000F00D, 0,
               17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h00206};
    vt[9]  = '{0, 17'h00101, 32'h0, 4'hF, 1, 1, 1, 32'h0, 0,
               17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h00206};
    vt[10] = '{1, 17'h1FFFC, 32'h89ABCDEF, 4'hF, 3, 0, 0, 32'h0, 2,
               17'h1FFFC, 16'hCDEF, 4'hF, 17'h1FFFE, 16'h89AB, 4'hF, 17'h1FFFE};
    vt[11] = '{0, 17'h1FFFC, 32'h0, 4'hF, 4, 0, 1, 32'h89ABCDEF, 0,
               17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h1FFFE};

    #12;
    chk("rst ready", {31'h0, req_ready}, 32'h0);
    chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst mem_ai", {15'h0, mem_ai}, 32'h0);
    chk("rst rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel ready early", {31'h0, req_ready}, 32'h0);

    for (int i = 0; i < 12; i++) run_req(vt[i], $sformatf("vec%0d", i));

    // back-to-back at the top of memory
    aiz_cnt = 0;
    @(negedge clk);
    wrap_en   = 1'b1;
    req_valid = 1'b1; req_we = 1'b0;
    req_addr  = 17'h1FFFC; req_be = 4'hF;
    chk("wrap ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_addr = 17'h00100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) chk("wrap hi ai", {15'h0, mem_ai}, 32'h1FFFE);
      if (c < 4) chk("wrap no rsp", {31'h0, rsp_valid}, 32'h0);
    end
    chk("wrap rsp", {31'h0, rsp_valid}, 32'h1);
    chk("wrap rdata", rsp_rdata, 32'h89ABCDEF);
    chk("b2b ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) chk("b2b no rsp", {31'h0, rsp_valid}, 32'h0);
    end
    chk("b2b rsp", {31'h0, rsp_valid}, 32'h1);
    chk("b2b rdata", rsp_rdata, 32'h12BB5678);
    wrap_en = 1'b0;
    chk("wrap ai zero", aiz_cnt, 0);

    // reset during HI of a write
    rv_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr  = 17'h00300; req_wdata = 32'h11112222; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rv_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort hi we", {31'h0, mem_we}, 32'h1);
    chk("abort hi ai", {15'h0, mem_ai}, 32'h00302);
    rst_n = 1'b0;
    #1;
    chk("abort we", {31'h0, mem_we}, 32'h0);
    chk("abort ready", {31'h0, req_ready}, 32'h0);
    chk("abort ai", {15'h0, mem_ai}, 32'h0);
    chk("abort vi", {16'h0, mem_vi}, 32'h0);
    chk("abort bmsk", {28'h0, mem_bmsk}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort rel ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1 chk("abort ready up", {31'h0, req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    rv_en = 1'b0;
    chk("abort no rsp", rv_cnt, 0);
    chk("abort lo mem", {16'h0, mem[16'h0180]}, 32'h2222);
    chk("abort hi mem", {16'h0, mem[16'h0181]}, 32'h0000);
    vr = '{0, 17'h00300, 32'h0, 4'hF, 4, 0, 1, 32'h00002222, 0,
           17'h0, 16'h0, 4'h0, 17'h0, 16'h0, 4'h0, 17'h00302};
    run_req(vr, "abort read");

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nbad);
    $finish;
  end

endmodule
